// File: rtl/uncache_agent_pkg.sv
// Shared types for the uncached-access agent: FSM states and write-buffer entries.
package uncache_agent_pkg;

  typedef enum logic [3:0] {
    StIdle   = 4'b0001,
    StWrBusy = 4'b0010,
    StRdBusy = 4'b0100,
    StRdDone = 4'b1000
  } ua_state_e;

  typedef struct packed {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } wbuf_entry_t;

endpackage

// File: rtl/uncache_agent_if.sv
// MEM-stage uncached data port (slave side of the agent) and the controller's uncache port
// (master side of the agent).
interface uncache_agent_if;

  logic        cpu_req;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stallreq;

  logic        uncache_en;
  logic [3:0]  uncache_wen;
  logic [31:0] uncache_addr;
  logic [31:0] uncache_wdata;
  logic [31:0] uncache_rdata;
  logic        uncache_refresh;

  modport slave (
    input  cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    output cpu_rdata, stallreq
  );

  modport master (
    output uncache_en, uncache_wen, uncache_addr, uncache_wdata,
    input  uncache_rdata, uncache_refresh
  );

endinterface

// File: rtl/uncache_wbuf.sv
// Posted-write FIFO; the head entry is presented combinationally on dout_o.
module uncache_wbuf
  import uncache_agent_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  wbuf_entry_t              din_i,
  output wbuf_entry_t              dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  wbuf_entry_t     mem_q [Depth];
  logic            do_push, do_pop;

  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap naturally because Depth is a power of two.
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uncache_agent.sv
// Orders uncached stores (posted, drained one at a time) and blocking loads onto the
// controller's uncache port, stalling the pipeline only when the buffer is full or a load waits.
module uncache_agent
  import uncache_agent_pkg::*;
#(
  parameter int unsigned WbufDepth = 4
) (
  input  logic              clk,
  input  logic              rstn,
  uncache_agent_if.slave    cpu,
  uncache_agent_if.master   unc,
  output logic              wbuf_empty_o
);

  ua_state_e   state_q, state_d;
  logic        en_q, en_d;
  logic [3:0]  wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rd_done_q, rd_done_d;

  logic        is_store, stall, push, pop, full, empty;
  wbuf_entry_t din, head;
  logic [$clog2(WbufDepth):0] count;

  assign is_store = |cpu.cpu_wen;
  assign stall    = cpu.cpu_req & ((is_store & full) | (~is_store & ~rd_done_q));
  assign push     = cpu.cpu_req & is_store & ~full;
  assign din      = '{wen: cpu.cpu_wen, addr: cpu.cpu_addr, wdata: cpu.cpu_wdata};

  uncache_wbuf #(.Depth(WbufDepth)) u_wbuf (
    .clk_i   (clk),
    .rst_ni  (rstn),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    wen_d     = wen_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rd_done_d = rd_done_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Buffered stores drain before any load so a load observes earlier writes.
        if (!empty) begin
          pop     = 1'b1;
          en_d    = 1'b1;
          wen_d   = head.wen;
          addr_d  = head.addr;
          wdata_d = head.wdata;
          state_d = StWrBusy;
        end else if (cpu.cpu_req && !is_store && !rd_done_q) begin
          en_d    = 1'b1;
          wen_d   = 4'b0000;
          addr_d  = cpu.cpu_addr;
          wdata_d = '0;
          state_d = StRdBusy;
        end
      end
      StWrBusy: begin
        if (unc.uncache_refresh) begin
          en_d    = 1'b0;
          wen_d   = 4'b0000;
          state_d = StIdle;
        end
      end
      StRdBusy: begin
        if (unc.uncache_refresh) begin
          rdata_d   = unc.uncache_rdata;
          rd_done_d = 1'b1;
          en_d      = 1'b0;
          state_d   = StRdDone;
        end
      end
      StRdDone: begin
        if (cpu.cpu_req && !stall) begin
          rd_done_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      en_q      <= 1'b0;
      wen_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rd_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rd_done_q <= rd_done_d;
    end
  end

  assign cpu.stallreq      = stall;
  assign cpu.cpu_rdata     = rdata_q;
  assign unc.uncache_en    = en_q;
  assign unc.uncache_wen   = wen_q;
  assign unc.uncache_addr  = addr_q;
  assign unc.uncache_wdata = wdata_q;
  assign wbuf_empty_o      = (count == '0) && (state_q != StWrBusy);

endmodule
